imm_encoder: RTL

//  Inverse of the core's immediate decode path: packs a 32-bit immediate plus register/opcode fields into I/S/B/U

---
 rtl/imm_encoder_pkg.sv | 25 ++
 rtl/imm_encoder_if.sv | 30 +++
 rtl/imm_field_packer.sv | 19 +
 rtl/imm_encoder.sv | 101 ++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared constants and the packer request record for imm_encoder.
// Optional immediate range checking is enabled with IMM_ENC_RANGE_CHECK_EN.
package imm_encoder_pkg;

    localparam logic [1:0]  FMT_I      = 2'd0;
    localparam logic [1:0]  FMT_S      = 2'd1;
    localparam logic [1:0]  FMT_B      = 2'd2;
    localparam logic [1:0]  FMT_U      = 2'd3;

    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [2:0]  F3_ADDI    = 3'b000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } pack_req_t;

endpackage

// File: rtl/imm_encoder_if.sv
// Request and instruction-word streams of imm_encoder, each valid/ready.
interface imm_encoder_if #(parameter int N = 32);
    logic         req_valid;
    logic         req_ready;
    logic         req_li;
    logic [1:0]   req_fmt;
    logic [6:0]   req_opcode;
    logic [2:0]   req_funct3;
    logic [4:0]   req_rd;
    logic [4:0]   req_rs1;
    logic [4:0]   req_rs2;
    logic [N-1:0] req_imm;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_instr;
    logic         out_last;
    logic         out_err;

    modport master (
        output req_valid, req_li, req_fmt, req_opcode, req_funct3,
               req_rd, req_rs1, req_rs2, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, out_last, out_err
    );

    modport slave (
        input  req_valid, req_li, req_fmt, req_opcode, req_funct3,
               req_rd, req_rs1, req_rs2, req_imm, out_ready,
        output req_ready, out_valid, out_instr, out_last, out_err
    );
endinterface

// File: rtl/imm_field_packer.sv
// Combinational packer: format + register/opcode fields + immediate -> instruction word.
module imm_field_packer
    import imm_encoder_pkg::*;
(
    input  pack_req_t   i_req,
    output logic [31:0] o_word
);
    always_comb begin
        o_word = '0;
        case (i_req.fmt)
            FMT_I:   o_word = {i_req.imm[11:0], i_req.rs1, i_req.f3, i_req.rd, i_req.op};
            FMT_S:   o_word = {i_req.imm[11:5], i_req.rs2, i_req.rs1, i_req.f3,
                               i_req.imm[4:0], i_req.op};
            FMT_B:   o_word = {i_req.imm[12], i_req.imm[10:5], i_req.rs2, i_req.rs1, i_req.f3,
                               i_req.imm[4:1], i_req.imm[11], i_req.op};
            default: o_word = {i_req.imm[31:12], i_req.rd, i_req.op};
        endcase
    end
endmodule

// File: rtl/imm_encoder.sv
// Immediate/instruction encoder with LI pseudo-op expansion into LUI/ADDI.
// Define IMM_ENC_RANGE_CHECK_EN to flag out-of-range immediates on out_err.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int N = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    imm_encoder_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT1 = 2'd1;
    localparam logic [1:0] S_BEAT2 = 2'd2;

    logic [1:0]   r_state;
    logic [N-1:0] r_instr, r_next;
    logic         r_last, r_err;

    logic [19:0]  w_hi;
    logic [11:0]  w_lo;
    logic         w_li_nop, w_li_two, w_acc, w_handoff, w_err;
    pack_req_t    w_p1, w_p2;
    logic [31:0]  w_word1, w_word2;

    // (imm + 0x800) >> 12 == imm[31:12] + imm[11], wrapping in 20 bits
    assign w_hi     = bus.req_imm[31:12] + {19'd0, bus.req_imm[11]};
    assign w_lo     = bus.req_imm[11:0];
    assign w_li_nop = (bus.req_rd == 5'd0);
    assign w_li_two = !w_li_nop && (w_hi != 20'd0) && (w_lo != 12'd0);

    always_comb begin
        w_p1 = '{fmt: bus.req_fmt, op: bus.req_opcode, f3: bus.req_funct3, rd: bus.req_rd,
                 rs1: bus.req_rs1, rs2: bus.req_rs2, imm: bus.req_imm};
        if (bus.req_li) begin
            if (w_li_nop)
                w_p1 = '{fmt: FMT_I, op: OPC_OPIMM, f3: F3_ADDI, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                         imm: 32'd0};
            else if (w_hi != 20'd0)
                w_p1 = '{fmt: FMT_U, op: OPC_LUI, f3: F3_ADDI, rd: bus.req_rd, rs1: 5'd0,
                         rs2: 5'd0, imm: {w_hi, 12'd0}};
            else
                w_p1 = '{fmt: FMT_I, op: OPC_OPIMM, f3: F3_ADDI, rd: bus.req_rd, rs1: 5'd0,
                         rs2: 5'd0, imm: {20'd0, w_lo}};
        end
    end

    assign w_p2 = '{fmt: FMT_I, op: OPC_OPIMM, f3: F3_ADDI, rd: bus.req_rd, rs1: bus.req_rd,
                    rs2: 5'd0, imm: {20'd0, w_lo}};

    imm_field_packer u_pack1 (.i_req(w_p1), .o_word(w_word1));
    imm_field_packer u_pack2 (.i_req(w_p2), .o_word(w_word2));

`ifdef IMM_ENC_RANGE_CHECK_EN
    always_comb begin
        case (bus.req_fmt)
            FMT_I, FMT_S: w_err = !((&bus.req_imm[31:11]) || !(|bus.req_imm[31:11]));
            FMT_B:        w_err = bus.req_imm[0] ||
                                  !((&bus.req_imm[31:12]) || !(|bus.req_imm[31:12]));
            default:      w_err = |bus.req_imm[11:0];
        endcase
        if (bus.req_li) w_err = 1'b0;
    end
`else
    assign w_err = 1'b0;
`endif

    assign bus.out_valid = (r_state != S_IDLE);
    assign bus.out_instr = r_instr;
    assign bus.out_last  = r_last;
    assign bus.out_err   = r_err;
    assign w_handoff     = bus.out_valid && bus.out_ready;
    assign bus.req_ready = (r_state == S_IDLE) || (w_handoff && r_last);
    assign w_acc         = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_next  <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_acc) begin
            r_state <= S_BEAT1;
            r_instr <= w_word1;
            r_next  <= w_word2;
            r_last  <= !(bus.req_li && w_li_two);
            r_err   <= w_err;
        end else if (w_handoff) begin
            // a non-last handoff can only be the LUI half of a two-word LI
            if (!r_last) begin
                r_state <= S_BEAT2;
                r_instr <= r_next;
                r_last  <= 1'b1;
                r_err   <= 1'b0;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end
endmodule
